tile_move_sequencer: RTL and testbench

Upstream feeder for the sliding-tile puzzle core. It buffers move requests from a host or a solver in a FIFO. It filters each move against a mirror of the 3x3 blank-space position: off-grid moves and immediate reversals are rejected. It issues at most one legal move per cycle as a registered direction/valid pair. The downstream puzzle core applies `out_dir` only in cycles where `out_valid` is high.

---
 rtl/tile_move_sequencer.sv | 163 ++++++++++++++++
 tb/tb_tile_move_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/tile_move_sequencer.sv
// Move-request FIFO feeding the sliding-tile puzzle core. It filters popped moves against a
// mirror of the blank position and the last issued direction, then issues legal moves registered.
module tile_move_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [1:0]               in_dir,
    output logic                     in_ready,
    input  logic                     hold,
    output logic                     out_valid,
    output logic [1:0]               out_dir,
    output logic                     reject_pulse,
    output logic [3:0]               space_loc,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         issued_count,
    output logic [CNT_W-1:0]         rejected_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_UP    = 2'b10,
        DIR_DOWN  = 2'b11
    } dir_t;

    logic [1:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             r_outValid;
    logic [1:0]       r_outDir;
    logic             r_reject;
    logic [1:0]       r_row;
    logic [1:0]       r_col;
    logic [1:0]       r_lastDir;
    logic             r_lastVld;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_rejected;

    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    logic [1:0] w_headDir;
    logic       w_inBounds;
    logic       w_reversal;
    logic       w_legal;
    logic [1:0] w_nextRow;
    logic [1:0] w_nextCol;

    assign w_full    = (r_level == LVL_W'(DEPTH));
    assign w_empty   = (r_level == '0);
    assign w_push    = in_valid && !w_full;
    assign w_pop     = !w_empty && !hold;
    assign w_headDir = r_mem[r_rdPtr];

    // Opposite directions differ only in the LSB (LEFT/RIGHT, UP/DOWN).
    assign w_reversal = r_lastVld && (w_headDir == {r_lastDir[1], ~r_lastDir[0]});
    assign w_legal    = w_inBounds && !w_reversal;

    always_comb begin
        w_inBounds = 1'b0;
        w_nextRow  = r_row;
        w_nextCol  = r_col;
        case (dir_t'(w_headDir))
            DIR_LEFT: begin
                w_inBounds = (r_col != 2'd0);
                w_nextCol  = r_col - 2'd1;
            end
            DIR_RIGHT: begin
                w_inBounds = (r_col < 2'd2);
                w_nextCol  = r_col + 2'd1;
            end
            DIR_UP: begin
                w_inBounds = (r_row != 2'd0);
                w_nextRow  = r_row - 2'd1;
            end
            DIR_DOWN: begin
                w_inBounds = (r_row < 2'd2);
                w_nextRow  = r_row + 2'd1;
            end
            default: w_inBounds = 1'b0;
        endcase
    end

    // Storage is not reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= in_dir;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_outDir   <= 2'b00;
            r_reject   <= 1'b0;
            r_row      <= 2'd2;
            r_col      <= 2'd2;
            r_lastDir  <= 2'b00;
            r_lastVld  <= 1'b0;
            r_issued   <= '0;
            r_rejected <= '0;
        end else begin
            r_outValid <= 1'b0;
            r_reject   <= 1'b0;
            if (w_pop) begin
                if (w_legal) begin
                    r_outValid <= 1'b1;
                    r_outDir   <= w_headDir;
                    r_row      <= w_nextRow;
                    r_col      <= w_nextCol;
                    r_lastDir  <= w_headDir;
                    r_lastVld  <= 1'b1;
                    if (r_issued != '1) begin
                        r_issued <= r_issued + 1'b1;
                    end
                end else begin
                    r_reject <= 1'b1;
                    if (r_rejected != '1) begin
                        r_rejected <= r_rejected + 1'b1;
                    end
                end
            end
        end
    end

    assign in_ready       = !w_full;
    assign out_valid      = r_outValid;
    assign out_dir        = r_outDir;
    assign reject_pulse   = r_reject;
    assign space_loc      = {r_row, r_col};
    assign level          = r_level;
    assign issued_count   = r_issued;
    assign rejected_count = r_rejected;

endmodule

// File: tb/tb_tile_move_sequencer.sv
// Scoreboard bench for tile_move_sequencer: directed moves queue their expected result and a
// negedge monitor compares every issue/reject; a CNT_W=2 copy shares the stimulus for saturation.
module tb_tile_move_sequencer;

    localparam int DEPTH = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    localparam logic [1:0] LEFT  = 2'b00;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] UP    = 2'b10;
    localparam logic [1:0] DOWN  = 2'b11;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             inValid = 1'b0;
    logic [1:0]       inDir = 2'b00;
    logic             hold = 1'b0;
    logic             inReady;
    logic             outValid;
    logic [1:0]       outDir;
    logic             rejectPulse;
    logic [3:0]       spaceLoc;
    logic [LVL_W-1:0] level;
    logic [7:0]       issuedCount;
    logic [7:0]       rejectedCount;

    logic             satInReady;
    logic             satOutValid;
    logic [1:0]       satOutDir;
    logic             satRejectPulse;
    logic [3:0]       satSpaceLoc;
    logic [LVL_W-1:0] satLevel;
    logic [1:0]       satIssuedCount;
    logic [1:0]       satRejectedCount;

    typedef struct packed {
        logic       isIssue;
        logic [1:0] dir;
        logic [3:0] loc;
    } exp_t;

    exp_t expQ[$];
    int   testsRun  = 0;
    int   failCount = 0;

    tile_move_sequencer #(.DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_dir(inDir), .in_ready(inReady),
        .hold(hold), .out_valid(outValid), .out_dir(outDir), .reject_pulse(rejectPulse),
        .space_loc(spaceLoc), .level(level), .issued_count(issuedCount),
        .rejected_count(rejectedCount)
    );

    tile_move_sequencer #(.DEPTH(DEPTH), .CNT_W(2)) satDut (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_dir(inDir), .in_ready(satInReady),
        .hold(hold), .out_valid(satOutValid), .out_dir(satOutDir),
        .reject_pulse(satRejectPulse), .space_loc(satSpaceLoc), .level(satLevel),
        .issued_count(satIssuedCount), .rejected_count(satRejectedCount)
    );

    always #5 clk = ~clk;

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            testsRun++;
            failCount++;
            $display("[TB] FAIL unexpectedMove: got valid=%0b reject=%0b dir=%0b, expected none",
                     outValid, rejectPulse, outDir);
        end else begin
            e = expQ.pop_front();
            checkValue("move",
                       {24'd0, outValid, rejectPulse, (outValid ? outDir : 2'b00), spaceLoc},
                       {24'd0, e.isIssue, ~e.isIssue, (e.isIssue ? e.dir : 2'b00), e.loc});
        end
    endtask

    // Monitor: every issue or reject the DUT presents is matched against the next expectation.
    always @(negedge clk) begin
        if (!reset && (outValid || rejectPulse)) begin
            checkOutput();
        end
    end

    task automatic applyStimulus(input logic [1:0] dir, input logic expectOut,
                                 input logic isIssue, input logic [3:0] loc);
        exp_t e;
        inValid = 1'b1;
        inDir   = dir;
        if (expectOut) begin
            e.isIssue = isIssue;
            e.dir     = dir;
            e.loc     = loc;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic doReset();
        inValid = 1'b0;
        hold    = 1'b0;
        reset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [1:0] fillDirs [DEPTH+1];
    logic       fillIssue [DEPTH+1];
    logic [3:0] fillLoc [DEPTH+1];
    int         drainCycles;

    initial begin
        fillDirs  = '{UP, UP, LEFT, LEFT, DOWN, RIGHT, RIGHT, RIGHT, DOWN};
        fillIssue = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        fillLoc   = '{4'b0110, 4'b0010, 4'b0001, 4'b0000, 4'b0100, 4'b0101, 4'b0110,
                      4'b0110, 4'b0110};

        doReset();
        checkValue("rstOutValid", {31'd0, outValid}, 32'd0);
        checkValue("rstOutDir", {30'd0, outDir}, 32'd0);
        checkValue("rstReject", {31'd0, rejectPulse}, 32'd0);
        checkValue("rstSpaceLoc", {28'd0, spaceLoc}, 32'b1010);
        checkValue("rstLevel", {28'd0, level}, 32'd0);
        checkValue("rstIssued", {24'd0, issuedCount}, 32'd0);
        checkValue("rstRejected", {24'd0, rejectedCount}, 32'd0);
        checkValue("rstInReady", {31'd0, inReady}, 32'd1);

        // UP then LEFT back to back: no bypass, then one issue per cycle.
        applyStimulus(UP, 1'b1, 1'b1, 4'b0110);
        checkValue("noBypassValid", {31'd0, outValid}, 32'd0);
        checkValue("noBypassLevel", {28'd0, level}, 32'd1);
        applyStimulus(LEFT, 1'b1, 1'b1, 4'b0101);
        checkValue("pushPopLevel", {28'd0, level}, 32'd1);
        checkValue("firstIssueLatency", {31'd0, outValid}, 32'd1);
        idle(3);
        checkValue("t1Issued", {24'd0, issuedCount}, 32'd2);
        checkValue("t1Rejected", {24'd0, rejectedCount}, 32'd0);
        checkValue("t1SpaceLoc", {28'd0, spaceLoc}, 32'b0101);

        // RIGHT from the right edge is off-grid.
        doReset();
        applyStimulus(RIGHT, 1'b1, 1'b0, 4'b1010);
        idle(3);
        checkValue("t2Rejected", {24'd0, rejectedCount}, 32'd1);
        checkValue("t2Issued", {24'd0, issuedCount}, 32'd0);
        checkValue("t2SpaceLoc", {28'd0, spaceLoc}, 32'b1010);

        // UP, DOWN (reversal), LEFT.
        applyStimulus(UP, 1'b1, 1'b1, 4'b0110);
        applyStimulus(DOWN, 1'b1, 1'b0, 4'b0110);
        applyStimulus(LEFT, 1'b1, 1'b1, 4'b0101);
        idle(3);
        checkValue("t3Issued", {24'd0, issuedCount}, 32'd2);
        checkValue("t3Rejected", {24'd0, rejectedCount}, 32'd2);
        checkValue("t3SpaceLoc", {28'd0, spaceLoc}, 32'b0101);

        // Hold while offering DEPTH+1 moves; the last one must bounce off a full FIFO.
        doReset();
        hold = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(fillDirs[i], (i < DEPTH), fillIssue[i], fillLoc[i]);
        end
        checkValue("fullLevel", {28'd0, level}, DEPTH);
        checkValue("fullInReady", {31'd0, inReady}, 32'd0);
        hold = 1'b0;
        drainCycles = 0;
        while (level != '0 && drainCycles < 20) begin
            @(posedge clk);
            #1;
            drainCycles++;
        end
        checkValue("drainCycles", drainCycles, DEPTH);
        idle(3);
        checkValue("t4Issued", {24'd0, issuedCount}, 32'd7);
        checkValue("t4Rejected", {24'd0, rejectedCount}, 32'd1);
        checkValue("t4SpaceLoc", {28'd0, spaceLoc}, 32'b0110);
        checkValue("t4SatIssued", {30'd0, satIssuedCount}, 32'd3);

        // Counter saturation on the narrow copy.
        doReset();
        applyStimulus(UP, 1'b1, 1'b1, 4'b0110);
        applyStimulus(LEFT, 1'b1, 1'b1, 4'b0101);
        applyStimulus(UP, 1'b1, 1'b1, 4'b0001);
        applyStimulus(LEFT, 1'b1, 1'b1, 4'b0000);
        applyStimulus(DOWN, 1'b1, 1'b1, 4'b0100);
        idle(3);
        checkValue("t5Issued", {24'd0, issuedCount}, 32'd5);
        checkValue("t5SatIssued", {30'd0, satIssuedCount}, 32'd3);
        checkValue("t5SatRejected", {30'd0, satRejectedCount}, 32'd0);

        // Asynchronous reset in the middle of a drain: only the first UP is ever seen.
        doReset();
        hold = 1'b1;
        applyStimulus(UP, 1'b1, 1'b1, 4'b0110);
        applyStimulus(LEFT, 1'b0, 1'b1, 4'b0101);
        applyStimulus(UP, 1'b0, 1'b1, 4'b0001);
        applyStimulus(LEFT, 1'b0, 1'b1, 4'b0000);
        hold = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkValue("asyncOutValid", {31'd0, outValid}, 32'd0);
        checkValue("asyncLevel", {28'd0, level}, 32'd0);
        checkValue("asyncSpaceLoc", {28'd0, spaceLoc}, 32'b1010);
        checkValue("asyncIssued", {24'd0, issuedCount}, 32'd0);
        #1;
        reset = 1'b0;
        idle(5);
        checkValue("postRstLevel", {28'd0, level}, 32'd0);
        checkValue("postRstIssued", {24'd0, issuedCount}, 32'd0);
        checkValue("pendingExpected", expQ.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
